// File: rtl/gost89_pkg.sv
// Shared types and constants for the GOST 28147-89 MAC sequencer and core.
package gost89_pkg;

  typedef enum logic [2:0] {IDLE, RUN, NEXT, PAD, DONE} state_t;

  typedef logic [63:0] block_t;

  localparam int BLOCK_BYTES = 8;
  localparam int CORE_ROUNDS = 16;

endpackage

// File: rtl/gost89_mac.sv
// GOST 28147-89 imitation (MAC) core: one round per clock, 16 rounds per block, chained by XOR.
// A load with reset high starts a fresh chain; busy rises after the load edge and falls 17 edges later.
module gost89_mac
  import gost89_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         load_data,
  input  logic [511:0] sbox,
  input  logic [255:0] key,
  input  block_t       in,
  output logic [31:0]  out,
  output logic         busy
);

  logic [31:0] n1;
  logic [31:0] n2;
  logic [4:0]  rnd;
  logic [31:0] round_key;
  logic [31:0] sum;
  logic [31:0] subst;
  logic [31:0] f_val;

  // Rounds 0..7 and 8..15 both walk K0..K7; K0 sits in key[255:224].
  always_comb begin
    round_key = key[{~rnd[2:0], 5'd0} +: 32];
    sum       = n1 + round_key;
    subst     = '0;
    for (int j = 0; j < 8; j++) begin
      subst[4*j +: 4] = sbox[{3'(j), sum[4*j +: 4], 2'b00} +: 4];
    end
    f_val = {subst[20:0], subst[31:21]};
  end

  always_ff @(posedge clk) begin
    if (load_data) begin
      n1   <= reset ? in[63:32] : (n1 ^ in[63:32]);
      n2   <= reset ? in[31:0]  : (n2 ^ in[31:0]);
      rnd  <= '0;
      busy <= 1'b1;
    end else if (reset) begin
      n1   <= '0;
      n2   <= '0;
      rnd  <= '0;
      busy <= 1'b0;
      out  <= '0;
    end else if (busy) begin
      if (rnd == 5'(CORE_ROUNDS)) begin
        busy <= 1'b0;
        out  <= n1;
      end else begin
        n1  <= n2 ^ f_val;
        n2  <= n1;
        rnd <= rnd + 5'd1;
      end
    end
  end

endmodule

// File: rtl/gost89_pad.sv
// Combinational zero-padding of the final block: bytes at index >= bytes are cleared (0 means all 8 kept).
module gost89_pad
  import gost89_pkg::*;
(
  input  block_t     data,
  input  logic       last,
  input  logic [2:0] bytes,
  output block_t     padded
);

  logic [3:0] keep;

  always_comb begin
    keep   = (!last || bytes == 3'd0) ? 4'(BLOCK_BYTES) : {1'b0, bytes};
    padded = data;
    for (int k = 0; k < BLOCK_BYTES; k++) begin
      if (k >= int'(keep)) padded[8*(BLOCK_BYTES-1-k) +: 8] = 8'h00;
    end
  end

endmodule

// File: rtl/gost89_mac_ctrl.sv
// Message sequencer around gost89_mac: pads, feeds one block per idle core, returns the MAC.
// Build option GOST89_MAC_CTRL_KEY_LATCH_EN captures key/sbox at the first block of each message.
module gost89_mac_ctrl
  import gost89_pkg::*;
#(
  parameter int MAC_BITS = 32,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [511:0]        sbox,
  input  logic [255:0]        key,
  input  logic                s_valid,
  output logic                s_ready,
  input  block_t              s_data,
  input  logic                s_last,
  input  logic [2:0]          s_bytes,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [MAC_BITS-1:0] m_mac,
  output logic [CNT_W-1:0]    m_blocks
);

  state_t            state;
  state_t            nxt;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_inc;
  logic              last_q;
  logic              transfer;
  logic              core_reset;
  logic              core_load;
  logic              core_busy;
  logic [31:0]       core_out;
  block_t            pad_data;
  block_t            core_in;
  logic [255:0]      core_key;
  logic [511:0]      core_sbox;

  assign transfer  = s_valid && s_ready;
  assign count_inc = (count == '1) ? count : count + CNT_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (transfer) nxt = RUN;
      RUN: begin
        if (!core_busy) begin
          if (!last_q)                 nxt = NEXT;
          else if (count == CNT_W'(1)) nxt = PAD;
          else                         nxt = DONE;
        end
      end
      NEXT:    if (transfer) nxt = RUN;
      PAD:     nxt = RUN;
      DONE:    if (m_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // s_ready is gated by reset_n so it reads 0 while reset is held even though state is IDLE.
  always_comb begin
    s_ready    = reset_n && (state == IDLE || state == NEXT);
    m_valid    = (state == DONE);
    core_load  = transfer || (state == PAD);
    core_reset = !reset_n || (state == IDLE);
    core_in    = (state == PAD) ? '0 : pad_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count    <= '0;
      last_q   <= 1'b0;
      m_mac    <= '0;
      m_blocks <= '0;
    end else begin
      if (transfer) begin
        count  <= (state == IDLE) ? CNT_W'(1) : count_inc;
        last_q <= s_last;
      end else if (state == PAD) begin
        count  <= count_inc;
      end
      if (state == RUN && nxt == DONE) begin
        m_mac    <= core_out[31 -: MAC_BITS];
        m_blocks <= count;
      end
    end
  end

`ifdef GOST89_MAC_CTRL_KEY_LATCH_EN
  logic [255:0] key_q;
  logic [511:0] sbox_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_q  <= '0;
      sbox_q <= '0;
    end else if (transfer && state == IDLE) begin
      key_q  <= key;
      sbox_q <= sbox;
    end
  end

  assign core_key  = key_q;
  assign core_sbox = sbox_q;
`else
  assign core_key  = key;
  assign core_sbox = sbox;
`endif

  gost89_pad u_pad (
    .data   (s_data),
    .last   (s_last),
    .bytes  (s_bytes),
    .padded (pad_data)
  );

  gost89_mac u_core (
    .clk       (clk),
    .reset     (core_reset),
    .load_data (core_load),
    .sbox      (core_sbox),
    .key       (core_key),
    .in        (core_in),
    .out       (core_out),
    .busy      (core_busy)
  );

endmodule

// File: tb/tb_gost89_mac_ctrl.sv
// Randomized bench for gost89_mac_ctrl against a message-level GOST MAC reference model.
module tb_gost89_mac_ctrl;

  localparam int CNT_W = 3;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [511:0] sbox = '0;
  logic [255:0] key = '0;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [63:0]  s_data = '0;
  logic         s_last = 1'b0;
  logic [2:0]   s_bytes = '0;
  logic         m_valid;
  logic         m_ready = 1'b0;
  logic [31:0]  m_mac;
  logic [CNT_W-1:0] m_blocks;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gost89_mac_ctrl #(.MAC_BITS(32), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .sbox     (sbox),
    .key      (key),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .s_last   (s_last),
    .s_bytes  (s_bytes),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_mac    (m_mac),
    .m_blocks (m_blocks)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  // GOST 28147-89 imitation: XOR block into state, 16 rounds with K0..K7 twice, MAC = left half.
  function automatic logic [31:0] model_mac(input logic [63:0] blks[$], input logic [255:0] k,
                                            input logic [511:0] sb);
    logic [31:0] a, b, t, s;
    a = 0;
    b = 0;
    foreach (blks[i]) begin
      a ^= blks[i][63:32];
      b ^= blks[i][31:0];
      for (int r = 0; r < 16; r++) begin
        t = a + k[255 - 32*(r % 8) -: 32];
        for (int j = 0; j < 8; j++) s[4*j +: 4] = sb[64*j + 4*t[4*j +: 4] +: 4];
        s = (s << 11) | (s >> 21);
        t = b ^ s;
        b = a;
        a = t;
      end
    end
    return a;
  endfunction

  function automatic logic [63:0] model_pad(input logic [63:0] d, input logic [2:0] nb);
    int keep;
    logic [63:0] r;
    keep = (nb == 0) ? 8 : int'(nb);
    r = d;
    for (int i = keep; i < 8; i++) r[63 - 8*i -: 8] = 8'h00;
    return r;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge with that edge's number.
  task automatic push_block(input logic [63:0] d, input bit last, input logic [2:0] nb,
                            output int acc);
    int t;
    t = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    s_bytes = nb;
    while (!s_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!s_ready) begin
      check("accept_timeout", 0, 1);
      acc = cyc;
    end else begin
      @(negedge clk);
      acc = cyc;
    end
  endtask

  task automatic run_msg(input string tag, input logic [63:0] raw[$], input logic [2:0] nb,
                         input int hold, input bit early_ready);
    logic [63:0] exp_q[$];
    logic [31:0] exp_mac;
    int n, acc, prev, t, exp_blk;
    n = raw.size();
    foreach (raw[i]) exp_q.push_back((i == n - 1) ? model_pad(raw[i], nb) : raw[i]);
    if (n == 1) exp_q.push_back(64'h0);
    exp_mac = model_mac(exp_q, key, sbox);
    exp_blk = (exp_q.size() > SAT) ? SAT : exp_q.size();
    m_ready = early_ready && hold == 0;
    prev = 0;
    for (int i = 0; i < n; i++) begin
      push_block(raw[i], i == n - 1, nb, acc);
      if (i > 0) check({tag, "_gap"}, 64'(acc - prev), 64'd19);
      prev = acc;
    end
    s_valid = 1'b0;
    t = 0;
    while (!m_valid && t < 200) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_latency"}, 64'(cyc - acc), (n == 1) ? 64'd37 : 64'd18);
    check({tag, "_mac"}, 64'(m_mac), 64'(exp_mac));
    check({tag, "_blocks"}, 64'(m_blocks), 64'(exp_blk));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_vld"}, 64'(m_valid), 64'd1);
      check({tag, "_hold_mac"}, 64'(m_mac), 64'(exp_mac));
      check({tag, "_hold_rdy"}, 64'(s_ready), 64'd0);
    end
    m_ready = 1'b1;
    @(negedge clk);
    check({tag, "_idle_vld"}, 64'(m_valid), 64'd0);
    check({tag, "_idle_rdy"}, 64'(s_ready), 64'd1);
    m_ready = 1'b0;
  endtask

  task automatic rand_keys();
    for (int i = 0; i < 16; i++) sbox[32*i +: 32] = $urandom;
    for (int i = 0; i < 8; i++)  key[32*i +: 32]  = $urandom;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] q[$];
    int acc;
    rand_keys();
    key = 256'h1;
    repeat (3) @(negedge clk);
    check("rst_s_ready", 64'(s_ready), 0);
    check("rst_m_valid", 64'(m_valid), 0);
    check("rst_m_mac", 64'(m_mac), 0);
    check("rst_m_blocks", 64'(m_blocks), 0);
    reset_n = 1'b1;
    @(negedge clk);
    check("rel_s_ready", 64'(s_ready), 1);

    q = {64'h0123456789ABCDEF};
    run_msg("one_blk", q, 3'd0, 0, 1'b0);

    rand_keys();
    q = {64'($urandom) << 32 | 64'($urandom), 64'($urandom) << 32 | 64'($urandom),
         64'($urandom) << 32 | 64'($urandom)};
    run_msg("three_blk", q, 3'd0, 10, 1'b0);

    q = {64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
    run_msg("partial", q, 3'd3, 0, 1'b1);

    q = {64'hFFFF_FFFF_FFFF_FFFF};
    run_msg("partial_one", q, 3'd3, 0, 1'b0);

    q = {};
    for (int i = 0; i < SAT + 2; i++) q.push_back({$urandom, $urandom});
    run_msg("saturate", q, 3'd0, 0, 1'b0);

    for (int m = 0; m < 5; m++) begin
      rand_keys();
      q = {};
      for (int i = 0, n = $urandom_range(1, 4); i < n; i++) q.push_back({$urandom, $urandom});
      run_msg($sformatf("rnd%0d", m), q, 3'($urandom_range(0, 7)), $urandom_range(0, 3),
              1'($urandom_range(0, 1)));
    end

    // Abort during RUN of block 2, then a fresh message must show no stale chaining.
    push_block({$urandom, $urandom}, 1'b0, 3'd0, acc);
    push_block({$urandom, $urandom}, 1'b0, 3'd0, acc);
    s_valid = 1'b0;
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("abort_s_ready", 64'(s_ready), 0);
    check("abort_m_valid", 64'(m_valid), 0);
    check("abort_m_mac", 64'(m_mac), 0);
    check("abort_m_blocks", 64'(m_blocks), 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    q = {{$urandom, $urandom}, {$urandom, $urandom}};
    run_msg("post_abort", q, 3'd5, 2, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
